// File: rtl/full_adder_pkg.sv
// Shared constants, types and the {cout,sum} reference function for full_adder.
package full_adder_pkg;

   localparam int unsigned FA_MAX_WIDTH = 64;
   localparam int unsigned FA_REF_W     = FA_MAX_WIDTH + 1;

   typedef logic [FA_MAX_WIDTH-1:0] fa_word_t;
   typedef logic [FA_REF_W-1:0]     fa_ref_t;

   // Low 'width' bits set; saturates at the full word.
   function automatic fa_word_t fa_mask(input int unsigned width);
      if (width >= FA_MAX_WIDTH) return '1;
      return (fa_word_t'(1) << width) - fa_word_t'(1);
   endfunction

   // Exact (width+1)-bit sum: bits [width-1:0] hold the sum, bit [width] the carry out.
   function automatic fa_ref_t fa_ref(input fa_word_t    a,
                                      input fa_word_t    b,
                                      input logic        cin,
                                      input int unsigned width);
      fa_word_t m;
      fa_ref_t  keep;
      fa_ref_t  full;
      m    = fa_mask(width);
      keep = fa_ref_t'(m) | (fa_ref_t'(1) << width);
      full = fa_ref_t'(a & m) + fa_ref_t'(b & m) + fa_ref_t'(cin);
      return full & keep;
   endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder leaf cell; chained through cin/cout by full_adder.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic prop;

   assign prop = a ^ b;
   assign s    = prop ^ cin;
   assign cout = (a & b) | (cin & prop);

endmodule

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with a combinational result and a registered copy.
// Define FULL_ADDER_OVF_EN to add signed-overflow outputs Ovf / Ovf_q.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic [WIDTH-1:0] S_q,
   output logic             Cout_q,
`ifdef FULL_ADDER_OVF_EN
   output logic             Ovf,
   output logic             Ovf_q,
`endif
   output logic             out_valid
);

   logic [WIDTH:0] carry;

   assign carry[0] = Cin;

   // Ripple chain: bit i consumes carry[i] and produces carry[i+1].
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_bit u_bit (
         .a    (A[i]),
         .b    (B[i]),
         .cin  (carry[i]),
         .s    (S[i]),
         .cout (carry[i+1])
      );
   end

   assign Cout = carry[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S_q       <= '0;
         Cout_q    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            S_q    <= S;
            Cout_q <= Cout;
         end
      end
   end

`ifdef FULL_ADDER_OVF_EN
   // Signed overflow: carry into the MSB differs from carry out of it.
   assign Ovf = carry[WIDTH] ^ carry[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Ovf_q <= 1'b0;
      end else if (in_valid) begin
         Ovf_q <= Ovf;
      end
   end
`endif

   // Cross-check the carry chain against the arithmetic reference; X inputs are left visible.
   fa_ref_t ref_sum;
   fa_ref_t dut_sum;

   assign ref_sum = fa_ref(fa_word_t'(A), fa_word_t'(B), Cin, WIDTH);
   assign dut_sum = fa_ref_t'({Cout, S});

   always @(posedge clk) begin
      if (rst_n && !$isunknown({A, B, Cin})) begin
         a_sum_matches_ref : assert (dut_sum == ref_sum);
      end
   end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at widths 1/4/8/16/64 against an arithmetic model.
module tb_full_adder;

   localparam int unsigned NI = 5;
   localparam int unsigned WL [NI] = '{1, 4, 8, 16, 64};
   localparam int unsigned I8 = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [63:0] a_in = '0;
   logic [63:0] b_in = '0;
   logic        cin_in = 1'b0;
   logic        vld_in = 1'b0;

   logic [63:0] s_arr  [NI];
   logic [63:0] sq_arr [NI];
   logic        cout_arr  [NI];
   logic        coutq_arr [NI];
   logic        ovf_arr   [NI];
   logic        ovfq_arr  [NI];
   logic        ov_arr    [NI];

   int n_checks = 0;
   int n_fail   = 0;

   logic [65:0] exp_q [NI][$];
   logic [65:0] held  [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned W = WL[g];
      logic [W-1:0] s;
      logic [W-1:0] s_q;
      logic         cout;
      logic         cout_q;
      logic         ovf;
      logic         ovf_q;
      logic         ovalid;

      full_adder #(.WIDTH(W)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .A         (a_in[W-1:0]),
         .B         (b_in[W-1:0]),
         .Cin       (cin_in),
         .in_valid  (vld_in),
         .S         (s),
         .Cout      (cout),
         .S_q       (s_q),
         .Cout_q    (cout_q),
`ifdef FULL_ADDER_OVF_EN
         .Ovf       (ovf),
         .Ovf_q     (ovf_q),
`endif
         .out_valid (ovalid)
      );

`ifndef FULL_ADDER_OVF_EN
      assign ovf   = 1'b0;
      assign ovf_q = 1'b0;
`endif

      assign s_arr[g]     = 64'(s);
      assign sq_arr[g]    = 64'(s_q);
      assign cout_arr[g]  = cout;
      assign coutq_arr[g] = cout_q;
      assign ovf_arr[g]   = ovf;
      assign ovfq_arr[g]  = ovf_q;
      assign ov_arr[g]    = ovalid;
   end

   // Expected {ovf, cout, sum} from plain integer arithmetic and the sign rule.
   function automatic logic [65:0] model(input int unsigned w, input logic [63:0] a,
                                         input logic [63:0] b, input logic c);
      logic [64:0] mask;
      logic [64:0] total;
      logic        sa, sb, ss;
      mask  = (w >= 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << w) - 65'd1);
      total = (65'(a) & mask) + (65'(b) & mask) + 65'(c);
      sa = a[w-1];
      sb = b[w-1];
      ss = total[w-1];
      return {(sa == sb) && (ss != sa), total[w], 64'(total & mask)};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_comb();
      logic [65:0] e;
      for (int i = 0; i < NI; i++) begin
         e = model(WL[i], a_in, b_in, cin_in);
         check($sformatf("S w%0d", WL[i]), s_arr[i], e[63:0]);
         check($sformatf("Cout w%0d", WL[i]), 64'(cout_arr[i]), 64'(e[64]));
`ifdef FULL_ADDER_OVF_EN
         check($sformatf("Ovf w%0d", WL[i]), 64'(ovf_arr[i]), 64'(e[65]));
`endif
      end
   endtask

   task automatic check_reset_regs(input string tag);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("%s out_valid w%0d", tag, WL[i]), 64'(ov_arr[i]), 64'd0);
         check($sformatf("%s S_q w%0d", tag, WL[i]), sq_arr[i], 64'd0);
         check($sformatf("%s Cout_q w%0d", tag, WL[i]), 64'(coutq_arr[i]), 64'd0);
`ifdef FULL_ADDER_OVF_EN
         check($sformatf("%s Ovf_q w%0d", tag, WL[i]), 64'(ovfq_arr[i]), 64'd0);
`endif
      end
   endtask

   task automatic flush();
      for (int i = 0; i < NI; i++) begin
         exp_q[i].delete();
         held[i] = '0;
      end
   endtask

   // Apply one vector at the falling edge, queue its registered result, check the comb path.
   task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic c, input logic v);
      @(negedge clk);
      a_in   = a;
      b_in   = b;
      cin_in = c;
      vld_in = v;
      if (v && rst_n) begin
         for (int i = 0; i < NI; i++) exp_q[i].push_back(model(WL[i], a, b, c));
      end
      #1;
      check_comb();
   endtask

   // Monitor: after each rising edge, every queued capture must appear exactly once.
   initial begin
      logic [65:0] e;
      logic        want;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++) begin
            want = (exp_q[i].size() != 0);
            check($sformatf("out_valid w%0d", WL[i]), 64'(ov_arr[i]), 64'(want));
            if (want) begin
               e = exp_q[i].pop_front();
               held[i] = e;
            end else begin
               e = held[i];
            end
            check($sformatf("S_q w%0d", WL[i]), sq_arr[i], e[63:0]);
            check($sformatf("Cout_q w%0d", WL[i]), 64'(coutq_arr[i]), 64'(e[64]));
`ifdef FULL_ADDER_OVF_EN
            check($sformatf("Ovf_q w%0d", WL[i]), 64'(ovfq_arr[i]), 64'(e[65]));
`endif
         end
      end
   end

   initial begin
      logic [7:0] s_tab;
      logic [7:0] c_tab;
      logic [2:0] k3;
      logic [63:0] ra, rb;

      flush();
      #1 rst_n = 1'b0;
      #1;
      check_reset_regs("reset");
      check_comb();

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Exhaustive 1-bit truth table.
      s_tab = 8'b1001_0110;
      c_tab = 8'b1110_1000;
      for (int k = 0; k < 8; k++) begin
         k3 = 3'(k);
         drive(64'(k3[2]), 64'(k3[1]), k3[0], 1'b1);
         check($sformatf("tt S k%0d", k), s_arr[0], 64'(s_tab[k]));
         check($sformatf("tt Cout k%0d", k), 64'(cout_arr[0]), 64'(c_tab[k]));
      end

      // 8-bit carry boundaries.
      drive(64'hFF, 64'h01, 1'b0, 1'b0);
      check("w8 FF+01 S", s_arr[I8], 64'h00);
      check("w8 FF+01 Cout", 64'(cout_arr[I8]), 64'd1);
      drive(64'hFF, 64'hFF, 1'b1, 1'b0);
      check("w8 FF+FF+1 S", s_arr[I8], 64'hFF);
      check("w8 FF+FF+1 Cout", 64'(cout_arr[I8]), 64'd1);
      drive(64'h0, 64'h0, 1'b0, 1'b0);
      check("w8 zero S", s_arr[I8], 64'h00);
      check("w8 zero Cout", 64'(cout_arr[I8]), 64'd0);

      // Single registered capture, then hold on an idle cycle.
      drive(64'h12, 64'h34, 1'b1, 1'b1);
      @(posedge clk);
      #2;
      check("w8 cap S_q", sq_arr[I8], 64'h47);
      check("w8 cap Cout_q", 64'(coutq_arr[I8]), 64'd0);
      check("w8 cap out_valid", 64'(ov_arr[I8]), 64'd1);
      drive(64'h0, 64'h0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      check("w8 idle out_valid", 64'(ov_arr[I8]), 64'd0);
      check("w8 idle S_q", sq_arr[I8], 64'h47);

      // Asynchronous reset between edges while a result is valid.
      drive(64'hF0, 64'h1F, 1'b1, 1'b1);
      @(posedge clk);
      #3;
      check("pre-reset out_valid", 64'(ov_arr[I8]), 64'd1);
      rst_n = 1'b0;
      flush();
      #1;
      check_reset_regs("midreset");
      check_comb();
      drive(64'h55, 64'hAA, 1'b1, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      vld_in = 1'b0;

`ifdef FULL_ADDER_OVF_EN
      drive(64'h7F, 64'h01, 1'b0, 1'b0);
      check("w8 7F+01 Ovf", 64'(ovf_arr[I8]), 64'd1);
      check("w8 7F+01 Cout", 64'(cout_arr[I8]), 64'd0);
      drive(64'h80, 64'h80, 1'b0, 1'b0);
      check("w8 80+80 Ovf", 64'(ovf_arr[I8]), 64'd1);
      check("w8 80+80 Cout", 64'(cout_arr[I8]), 64'd1);
      check("w8 80+80 S", s_arr[I8], 64'h00);
`endif

      // Random vectors with occasional all-ones operands.
      for (int n = 0; n < 10000; n++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         if ((n % 16) == 0) begin
            drive('1, '1, 1'b1, 1'($urandom_range(0, 1)));
         end else begin
            drive(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end

      drive(64'h0, 64'h0, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
